ddr3_burst_sched: RTL and testbench

//  Sequences one MCB write port (p2) and one MCB read port (p3) through a single FSM.

---
 rtl/ddr3_burst_sched.sv | 173 +++++++++++++++++
 tb/tb_ddr3_burst_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_burst_sched.sv
// Burst scheduler for one MCB write port (p2) and one MCB read port (p3).
// Drains fixed-length bursts from an FWFT FIFO and replays them downstream in order.
module ddr3_burst_sched #(
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_ADDR  = 1024,
  parameter int unsigned PEND_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calib_done,
  input  logic              up_empty,
  input  logic              up_burst_rdy,
  input  logic [31:0]       up_data,
  output logic              up_rd_en,
  input  logic              rd_req,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              p2_cmd_en,
  output logic [5:0]        p2_cmd_bl,
  output logic [29:0]       p2_cmd_byte_addr,
  input  logic              p2_cmd_full,
  output logic              p2_wr_en,
  output logic [31:0]       p2_wr_data,
  output logic [3:0]        p2_wr_mask,
  input  logic              p2_wr_full,
  output logic              p3_cmd_en,
  output logic [5:0]        p3_cmd_bl,
  output logic [29:0]       p3_cmd_byte_addr,
  input  logic              p3_cmd_full,
  output logic              p3_rd_en,
  input  logic [31:0]       p3_rd_data,
  input  logic              p3_rd_empty,
  output logic              busy,
  output logic [PEND_W-1:0] pending
);

  localparam logic [29:0]       STRIDE    = 30'(BURST_LEN * 4);
  localparam logic [29:0]       BASE30    = 30'(BASE_ADDR);
  localparam logic [30:0]       MAX31     = 31'(MAX_ADDR);
  localparam logic [6:0]        LAST_BEAT = 7'(BURST_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_CMD,
    RD_CMD,
    RD_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [29:0]       wr_addr_q, wr_addr_d;
  logic [29:0]       rd_addr_q, rd_addr_d;
  logic [6:0]        beat_q, beat_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              last_wr_q, last_wr_d;
  logic              wr_ok, rd_ok;

  // Ring-buffer advance; the sum is taken one bit wider so the wrap test cannot overflow.
  function automatic logic [29:0] next_addr(input logic [29:0] a);
    logic [30:0] s;
    s = {1'b0, a} + {1'b0, STRIDE};
    next_addr = (s >= MAX31) ? BASE30 : s[29:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_addr_q <= BASE30;
      rd_addr_q <= BASE30;
      beat_q    <= '0;
      pending_q <= '0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      beat_q    <= beat_d;
      pending_q <= pending_d;
      last_wr_q <= last_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    beat_d    = beat_q;
    pending_d = pending_q;
    last_wr_d = last_wr_q;
    wr_ok     = 1'b0;
    rd_ok     = 1'b0;
    p2_wr_en  = 1'b0;
    p2_cmd_en = 1'b0;
    p3_cmd_en = 1'b0;
    p3_rd_en  = 1'b0;

    case (state_q)
      IDLE: begin
        wr_ok = calib_done & up_burst_rdy & (pending_q != PEND_MAX);
        rd_ok = calib_done & rd_req & (pending_q != '0);
        // On contention the side not served last wins.
        if (wr_ok && (!rd_ok || !last_wr_q)) begin
          state_d = WR_DATA;
        end else if (rd_ok) begin
          state_d = RD_CMD;
        end
      end

      WR_DATA: begin
        p2_wr_en = ~up_empty & ~p2_wr_full;
        if (p2_wr_en) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = WR_CMD;
          end else begin
            beat_d = beat_q + 7'd1;
          end
        end
      end

      WR_CMD: begin
        p2_cmd_en = ~p2_cmd_full;
        if (p2_cmd_en) begin
          wr_addr_d = next_addr(wr_addr_q);
          pending_d = pending_q + PEND_ONE;
          last_wr_d = 1'b1;
          state_d   = IDLE;
        end
      end

      RD_CMD: begin
        p3_cmd_en = ~p3_cmd_full;
        if (p3_cmd_en) begin
          rd_addr_d = next_addr(rd_addr_q);
          pending_d = pending_q - PEND_ONE;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        p3_rd_en = ~p3_rd_empty & rd_ready;
        if (p3_rd_en) begin
          if (beat_q == LAST_BEAT) begin
            beat_d    = '0;
            last_wr_d = 1'b0;
            state_d   = IDLE;
          end else begin
            beat_d = beat_q + 7'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign up_rd_en         = p2_wr_en;
  assign p2_wr_data       = up_data;
  assign p2_wr_mask       = '0;
  assign p2_cmd_bl        = 6'(BURST_LEN - 1);
  assign p2_cmd_byte_addr = wr_addr_q;
  assign p3_cmd_bl        = 6'(BURST_LEN - 1);
  assign p3_cmd_byte_addr = rd_addr_q;
  assign rd_valid         = p3_rd_en;
  assign rd_data          = p3_rd_data;
  assign busy             = (state_q != IDLE);
  assign pending          = pending_q;

endmodule

// File: tb/tb_ddr3_burst_sched.sv
// Randomized bench for ddr3_burst_sched: transaction-level model of the upstream FIFO,
// MCB memory, arbitration rule and downstream data order.
module tb_ddr3_burst_sched;

  localparam int BL    = 4;
  localparam int BASE  = 32;
  localparam int MAXA  = 144;
  localparam int PW    = 3;
  localparam int SLOTS = (MAXA - BASE) / (BL * 4);
  localparam int PMAX  = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst, calib_done, up_empty, up_burst_rdy, up_rd_en;
  logic [31:0]   up_data;
  logic          rd_req, rd_ready, rd_valid;
  logic [31:0]   rd_data;
  logic          p2_cmd_en, p2_cmd_full, p2_wr_en, p2_wr_full;
  logic [5:0]    p2_cmd_bl;
  logic [29:0]   p2_cmd_byte_addr;
  logic [31:0]   p2_wr_data;
  logic [3:0]    p2_wr_mask;
  logic          p3_cmd_en, p3_cmd_full, p3_rd_en, p3_rd_empty;
  logic [5:0]    p3_cmd_bl;
  logic [29:0]   p3_cmd_byte_addr;
  logic [31:0]   p3_rd_data;
  logic          busy;
  logic [PW-1:0] pending;

  ddr3_burst_sched #(
    .BURST_LEN(BL),
    .BASE_ADDR(BASE),
    .MAX_ADDR (MAXA),
    .PEND_W   (PW)
  ) dut (
    .clk(clk), .rst(rst), .calib_done(calib_done),
    .up_empty(up_empty), .up_burst_rdy(up_burst_rdy), .up_data(up_data), .up_rd_en(up_rd_en),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .p2_cmd_en(p2_cmd_en), .p2_cmd_bl(p2_cmd_bl), .p2_cmd_byte_addr(p2_cmd_byte_addr),
    .p2_cmd_full(p2_cmd_full), .p2_wr_en(p2_wr_en), .p2_wr_data(p2_wr_data),
    .p2_wr_mask(p2_wr_mask), .p2_wr_full(p2_wr_full),
    .p3_cmd_en(p3_cmd_en), .p3_cmd_bl(p3_cmd_bl), .p3_cmd_byte_addr(p3_cmd_byte_addr),
    .p3_cmd_full(p3_cmd_full), .p3_rd_en(p3_rd_en), .p3_rd_data(p3_rd_data),
    .p3_rd_empty(p3_rd_empty), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks, errors;

  // stimulus knobs
  bit rst_drv, calib_drv;
  int fill_pct, rd_req_pct, ready_pct, stall_pct;

  // reference model: queues and counters, one in-flight transaction
  logic [31:0] upq[$], retq[$], exp_stream[$], burst_buf[$];
  logic [31:0] mem [SLOTS*BL];
  int pend, tk, tbeats, prev_grant, exp_waddr, exp_raddr;
  bit tcmd, last_wr;

  task automatic chk_b(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int adv(int a);
    return (a + BL * 4 >= MAXA) ? BASE : a + BL * 4;
  endfunction

  task automatic model_reset();
    pend = 0; last_wr = 0; tk = 0; tbeats = 0; tcmd = 0; prev_grant = -1;
    exp_waddr = BASE; exp_raddr = BASE;
    exp_stream.delete(); retq.delete(); burst_buf.delete();
  endtask

  task automatic sample();
    bit e_p2w, e_p2c, e_p3c, e_p3r, wr_ok, rd_ok;
    int slot;
    if (prev_grant >= 0) begin
      chk_b("grant_latency", busy, prev_grant != 0);
      if (prev_grant != 0) begin
        tk = prev_grant; tbeats = 0; tcmd = 0; burst_buf.delete();
      end
    end
    chk_b("busy", busy, tk != 0);
    chk_w("pending", 32'(pending), pend);
    chk_w("wr_mask", 32'(p2_wr_mask), 0);

    e_p2w = (tk == 1) && (tbeats < BL) && !up_empty && !p2_wr_full;
    e_p2c = (tk == 1) && (tbeats == BL) && !p2_cmd_full;
    e_p3c = (tk == 2) && !tcmd && !p3_cmd_full;
    e_p3r = (tk == 2) && tcmd && !p3_rd_empty && rd_ready;
    chk_b("p2_wr_en", p2_wr_en, e_p2w);
    chk_b("up_rd_en", up_rd_en, e_p2w);
    chk_b("p2_cmd_en", p2_cmd_en, e_p2c);
    chk_b("p3_cmd_en", p3_cmd_en, e_p3c);
    chk_b("p3_rd_en", p3_rd_en, e_p3r);
    chk_b("rd_valid", rd_valid, e_p3r);

    prev_grant = -1;
    if (tk == 0 && !rst) begin
      wr_ok = calib_done && up_burst_rdy && (pend != PMAX);
      rd_ok = calib_done && rd_req && (pend != 0);
      if (wr_ok && (!rd_ok || !last_wr)) prev_grant = 1;
      else if (rd_ok)                    prev_grant = 2;
      else                               prev_grant = 0;
    end

    if (e_p2w) begin
      chk_w("p2_wr_data", p2_wr_data, upq[0]);
      burst_buf.push_back(upq.pop_front());
      tbeats++;
    end
    if (e_p2c) begin
      chk_w("p2_cmd_bl", 32'(p2_cmd_bl), BL - 1);
      chk_w("p2_cmd_addr", 32'(p2_cmd_byte_addr), exp_waddr);
      slot = (exp_waddr - BASE) / (BL * 4);
      for (int i = 0; i < BL; i++) begin
        mem[slot*BL + i] = burst_buf[i];
        exp_stream.push_back(burst_buf[i]);
      end
      exp_waddr = adv(exp_waddr);
      pend++; last_wr = 1; tk = 0;
    end
    if (e_p3c) begin
      chk_w("p3_cmd_bl", 32'(p3_cmd_bl), BL - 1);
      chk_w("p3_cmd_addr", 32'(p3_cmd_byte_addr), exp_raddr);
      slot = (exp_raddr - BASE) / (BL * 4);
      for (int i = 0; i < BL; i++) retq.push_back(mem[slot*BL + i]);
      exp_raddr = adv(exp_raddr);
      pend--; tcmd = 1; tbeats = 0;
    end
    if (e_p3r) begin
      if (exp_stream.size() > 0) chk_w("rd_data_order", rd_data, exp_stream.pop_front());
      void'(retq.pop_front());
      tbeats++;
      if (tbeats == BL) begin
        tk = 0; last_wr = 0;
      end
    end
    if (rst) model_reset();
  endtask

  task automatic cycle();
    @(negedge clk);
    if (fill_pct > 0 && upq.size() < 3 * BL && $urandom_range(99) < fill_pct)
      upq.push_back($urandom());
    rst          = rst_drv;
    calib_done   = calib_drv;
    up_empty     = (upq.size() == 0);
    up_burst_rdy = (upq.size() >= BL);
    up_data      = (upq.size() == 0) ? $urandom() : upq[0];
    rd_req       = ($urandom_range(99) < rd_req_pct);
    rd_ready     = ($urandom_range(99) < ready_pct);
    p2_wr_full   = ($urandom_range(99) < stall_pct);
    p2_cmd_full  = ($urandom_range(99) < stall_pct);
    p3_cmd_full  = ($urandom_range(99) < stall_pct);
    p3_rd_empty  = (retq.size() == 0) || ($urandom_range(99) < stall_pct);
    p3_rd_data   = (retq.size() == 0) ? $urandom() : retq[0];
    if (rst_drv) begin
      p2_wr_full = 1'b1; p2_cmd_full = 1'b1; p3_cmd_full = 1'b1;
      p3_rd_empty = 1'b1; rd_ready = 1'b0;
    end
    #1;
    sample();
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    rst = 1'b1; calib_done = 1'b0; up_empty = 1'b1; up_burst_rdy = 1'b0; up_data = '0;
    rd_req = 1'b0; rd_ready = 1'b0; p2_cmd_full = 1'b0; p2_wr_full = 1'b0;
    p3_cmd_full = 1'b0; p3_rd_empty = 1'b1; p3_rd_data = '0;
    rst_drv = 0; calib_drv = 0; fill_pct = 0; rd_req_pct = 0; ready_pct = 100; stall_pct = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_b("rst_busy", busy, 1'b0);
    chk_w("rst_pending", 32'(pending), 0);
    chk_b("rst_p2_wr_en", p2_wr_en, 1'b0);
    chk_b("rst_p2_cmd_en", p2_cmd_en, 1'b0);
    chk_b("rst_p3_cmd_en", p3_cmd_en, 1'b0);
    chk_b("rst_p3_rd_en", p3_rd_en, 1'b0);
    chk_w("rst_wr_addr", 32'(p2_cmd_byte_addr), BASE);
    chk_w("rst_rd_addr", 32'(p3_cmd_byte_addr), BASE);

    // read request with nothing written: no grant
    calib_drv = 1; rd_req_pct = 100;
    repeat (20) cycle();
    // calibration low: data and read request present, still no grant
    calib_drv = 0; fill_pct = 100;
    repeat (20) cycle();
    chk_b("uncal_no_grant", busy, 1'b0);
    // first write burst, no stalls
    calib_drv = 1; rd_req_pct = 0;
    n = 0;
    while (!(pend == 1 && tk == 0) && n < 100) begin cycle(); n++; end
    chk_b("first_burst_timeout", n < 100, 1'b1);
    // both sides requesting: alternation
    rd_req_pct = 100;
    repeat (40) cycle();
    // fill to the pending ceiling, then writes must stop
    rd_req_pct = 0;
    n = 0;
    while (!(pend == PMAX && tk == 0) && n < 600) begin cycle(); n++; end
    chk_b("fill_timeout", n < 600, 1'b1);
    repeat (20) cycle();
    chk_w("pend_ceiling", 32'(pending), PMAX);
    // random traffic with stalls and calibration drops
    rd_req_pct = 50; ready_pct = 50; stall_pct = 30; fill_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      calib_drv = ($urandom_range(99) < 95);
      cycle();
    end
    // drain everything written
    calib_drv = 1; rd_req_pct = 100; ready_pct = 100; stall_pct = 0; fill_pct = 0;
    n = 0;
    while (!(pend == 0 && tk == 0) && n < 1000) begin cycle(); n++; end
    chk_b("drain_timeout", n < 1000, 1'b1);
    chk_w("stream_drained", exp_stream.size(), 0);
    // reset in the middle of a write burst at beat 2
    rd_req_pct = 0; fill_pct = 100;
    n = 0;
    while (!(tk == 1 && tbeats == 2) && n < 200) begin cycle(); n++; end
    chk_b("beat2_timeout", n < 200, 1'b1);
    rst_drv = 1; cycle();
    rst_drv = 0; calib_drv = 0; cycle();
    chk_b("post_rst_busy", busy, 1'b0);
    chk_w("post_rst_wr_addr", 32'(p2_cmd_byte_addr), BASE);
    chk_w("post_rst_rd_addr", 32'(p3_cmd_byte_addr), BASE);
    chk_w("post_rst_pending", 32'(pending), 0);
    rd_req_pct = 100;
    repeat (20) cycle();
    // resume after reset: first burst lands at the base address again
    calib_drv = 1; rd_req_pct = 0;
    n = 0;
    while (!(pend == 1 && tk == 0) && n < 100) begin cycle(); n++; end
    chk_b("resume_timeout", n < 100, 1'b1);
    rd_req_pct = 100; fill_pct = 0;
    n = 0;
    while (!(pend == 0 && tk == 0) && n < 200) begin cycle(); n++; end
    chk_b("final_drain_timeout", n < 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
